// File: rtl/coffee_1058_pkg.sv
// Shared types and constants for the coffee_1058 coin-operated controller.
package coffee_1058_pkg;

  localparam int unsigned CREDIT_W = 8;
  localparam int unsigned CENT20   = 20;
  localparam int unsigned CENT50   = 50;
  localparam int unsigned EURO01   = 100;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    BREW    = 3'd2,
    CUP     = 3'd3,
    REFUND  = 3'd4
  } state_e;

  // Value of all coins whose edge fired this cycle; bit0=20ct, bit1=50ct, bit2=1 EUR.
  function automatic logic [CREDIT_W-1:0] coin_sum(input logic [2:0] rise);
    logic [CREDIT_W-1:0] s;
    s = '0;
    if (rise[0]) s = s + CREDIT_W'(CENT20);
    if (rise[1]) s = s + CREDIT_W'(CENT50);
    if (rise[2]) s = s + CREDIT_W'(EURO01);
    return s;
  endfunction

endpackage

// File: rtl/coffee_1058_coin_edge_det.sv
// Registered rising-edge detector for the three coin inputs.
module coin_edge_det (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [2:0] coin_i,
  output logic [2:0] rise_c_o
);

  logic [2:0] prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) prev_q <= '0;
    else         prev_q <= coin_i;
  end

  assign rise_c_o = coin_i & ~prev_q;

endmodule

// File: rtl/coffee_1058.sv
// Coffee-machine controller: coin credit accumulation, brew/cup handshake, refund.
module coffee_1058
  import coffee_1058_pkg::*;
#(
  parameter int unsigned PRICE_CENTS = 60
) (
  input  logic clk4m,
  input  logic rst_n,
  input  logic cent20,
  input  logic cent50,
  input  logic euro01,
  input  logic stop_buy,
  input  logic coffee_ready,
  input  logic cup_out,
  output logic prepare_coffee,
  output logic green,
  output logic return_cash,
  output logic lock_slit
);

  // One extra bit so credit plus a burst of coins can never wrap before the compare.
  localparam logic [CREDIT_W:0] PRICE = (CREDIT_W+1)'(PRICE_CENTS);

  logic [2:0]          rise_c;
  logic [CREDIT_W:0]   sum_c;
  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                prepare_q, prepare_d;
  logic                green_q, green_d;
  logic                return_q, return_d;
  logic                lock_q, lock_d;

  coin_edge_det u_edge (
    .clk_i    (clk4m),
    .rst_ni   (rst_n),
    .coin_i   ({euro01, cent50, cent20}),
    .rise_c_o (rise_c)
  );

  assign sum_c = {1'b0, credit_q} + {1'b0, coin_sum(rise_c)};

  always_ff @(posedge clk4m or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      credit_q  <= '0;
      prepare_q <= 1'b0;
      green_q   <= 1'b0;
      return_q  <= 1'b0;
      lock_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      credit_q  <= credit_d;
      prepare_q <= prepare_d;
      green_q   <= green_d;
      return_q  <= return_d;
      lock_q    <= lock_d;
    end
  end

  // Next state and credit; outputs are the Moore decode of the next state, so they
  // land in registers aligned with the state register.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    unique case (state_q)
      IDLE: begin
        credit_d = '0;
        if (sum_c >= PRICE) begin
          state_d = BREW;
        end else if (sum_c != '0) begin
          state_d  = COLLECT;
          credit_d = sum_c[CREDIT_W-1:0];
        end
      end
      COLLECT: begin
        if (sum_c >= PRICE) begin
          state_d  = BREW;
          credit_d = '0;
        end else if (stop_buy) begin
          state_d  = REFUND;
          credit_d = '0;
        end else begin
          credit_d = sum_c[CREDIT_W-1:0];
        end
      end
      BREW: begin
        credit_d = '0;
        if (coffee_ready) state_d = CUP;
      end
      CUP: begin
        credit_d = '0;
        if (cup_out) state_d = IDLE;
      end
      REFUND: begin
        credit_d = '0;
        state_d  = IDLE;
      end
      default: begin
        state_d  = IDLE;
        credit_d = '0;
      end
    endcase

    prepare_d = (state_d == BREW);
    green_d   = (state_d == CUP);
    return_d  = (state_d == REFUND);
    lock_d    = (state_d == BREW) || (state_d == CUP);
  end

  assign prepare_coffee = prepare_q;
  assign green          = green_q;
  assign return_cash    = return_q;
  assign lock_slit      = lock_q;

endmodule

// File: tb/tb_coffee_1058.sv
// Directed self-checking bench for coffee_1058 (price 60 ct).
`timescale 1ns/1ps
module tb_coffee_1058;

  logic clk4m = 1'b0;
  logic rst_n;
  logic cent20, cent50, euro01, stop_buy, coffee_ready, cup_out;
  logic prepare_coffee, green, return_cash, lock_slit;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  // Output vector order: {prepare_coffee, green, return_cash, lock_slit}
  localparam logic [3:0] O_NONE = 4'b0000;
  localparam logic [3:0] O_BREW = 4'b1001;
  localparam logic [3:0] O_CUP  = 4'b0101;
  localparam logic [3:0] O_REF  = 4'b0010;

  always #125 clk4m = ~clk4m;

  coffee_1058 #(.PRICE_CENTS(60)) dut (
    .clk4m          (clk4m),
    .rst_n          (rst_n),
    .cent20         (cent20),
    .cent50         (cent50),
    .euro01         (euro01),
    .stop_buy       (stop_buy),
    .coffee_ready   (coffee_ready),
    .cup_out        (cup_out),
    .prepare_coffee (prepare_coffee),
    .green          (green),
    .return_cash    (return_cash),
    .lock_slit      (lock_slit)
  );

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] outs();
    return {prepare_coffee, green, return_cash, lock_slit};
  endfunction

  task automatic tick();
    @(posedge clk4m);
    #1;
  endtask

  // One-cycle coin pulse followed by a low cycle so the next pulse is a fresh edge.
  task automatic coin(input logic [2:0] c);
    {euro01, cent50, cent20} = c;
    tick();
    {euro01, cent50, cent20} = 3'b000;
    tick();
  endtask

  task automatic pulse_ready();
    coffee_ready = 1'b1; tick(); coffee_ready = 1'b0;
  endtask

  task automatic pulse_cup();
    cup_out = 1'b1; tick(); cup_out = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    {euro01, cent50, cent20} = 3'b000;
    stop_buy = 1'b0; coffee_ready = 1'b0; cup_out = 1'b0;
    tick(); tick();
    check("reset", outs(), O_NONE);
    rst_n = 1'b1;
    tick();
    check("idle_after_reset", outs(), O_NONE);

    // 3 x 20 ct: brewing starts the cycle after the third coin edge
    coin(3'b001); check("c20_1", outs(), O_NONE);
    coin(3'b001); check("c20_2", outs(), O_NONE);
    cent20 = 1'b1; tick(); cent20 = 1'b0;
    check("c20_3_brew", outs(), O_BREW);
    tick();
    check("brew_hold", outs(), O_BREW);
    pulse_ready(); check("cup_lamp", outs(), O_CUP);
    tick();        check("cup_hold", outs(), O_CUP);
    pulse_cup();   check("cup_taken", outs(), O_NONE);

    // 20 + 50 = 70: overpayment, straight to brew, no refund
    coin(3'b001); check("p70_20", outs(), O_NONE);
    coin(3'b010); check("p70_brew", outs(), O_BREW);
    pulse_ready(); pulse_cup();
    check("p70_done", outs(), O_NONE);

    // 40 ct then cancel: single-cycle refund, credit cleared
    coin(3'b001); coin(3'b001);
    stop_buy = 1'b1; tick(); stop_buy = 1'b0;
    check("refund_pulse", outs(), O_REF);
    tick();
    check("refund_end", outs(), O_NONE);
    coin(3'b001); check("after_ref_20", outs(), O_NONE);
    coin(3'b001); check("after_ref_40", outs(), O_NONE);
    coin(3'b001); check("after_ref_60", outs(), O_BREW);
    pulse_ready(); pulse_cup();

    // 1 EUR from idle; 20 ct coins during brew are discarded
    coin(3'b100); check("euro_brew", outs(), O_BREW);
    coin(3'b001); coin(3'b001); coin(3'b001);
    check("brew_ignores_coins", outs(), O_BREW);
    pulse_ready(); pulse_cup();
    check("euro_done", outs(), O_NONE);
    coin(3'b001); coin(3'b001);
    check("no_carry_40", outs(), O_NONE);
    coin(3'b001); check("no_carry_60", outs(), O_BREW);
    pulse_ready(); pulse_cup();

    // Asynchronous reset mid-brew
    coin(3'b011); check("dual_coin_brew", outs(), O_BREW);
    rst_n = 1'b0;
    #1;
    check("async_reset", outs(), O_NONE);
    tick();
    rst_n = 1'b1;
    tick();
    pulse_ready(); tick();
    check("idle_ignores_ready", outs(), O_NONE);
    stop_buy = 1'b1; tick(); stop_buy = 1'b0; tick();
    check("idle_ignores_stop", outs(), O_NONE);

    // 50 ct held 5 cycles counts once
    cent50 = 1'b1;
    repeat (5) tick();
    cent50 = 1'b0;
    tick();
    check("held_50_once", outs(), O_NONE);
    coin(3'b001); check("held_50_plus_20", outs(), O_BREW);
    pulse_ready();
    stop_buy = 1'b1; tick(); stop_buy = 1'b0; tick();
    check("cup_ignores_stop", outs(), O_CUP);
    pulse_cup(); check("held_done", outs(), O_NONE);

    // Coin reaching price wins over a simultaneous cancel
    coin(3'b001); coin(3'b001);
    cent20 = 1'b1; stop_buy = 1'b1; tick();
    cent20 = 1'b0; stop_buy = 1'b0;
    check("coin_beats_stop", outs(), O_BREW);
    pulse_ready(); pulse_cup(); tick();
    check("final_idle", outs(), O_NONE);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/coffee_1058.md
# coffee_1058

Coin-operated coffee-machine controller. Accepts 20 ct, 50 ct and 1 € coins and accumulates credit until the price is reached. It then commands the brewer, waits for the brewer's done signal and for cup removal, and returns to idle. A cancel input during payment refunds the collected cash. It sits between the coin slit/keypad front end and the brewing unit, clocked at 4 MHz.

## Interface
- PRICE_CENTS, default 60: coffee price in cents. Legal range 20..255.
- clk4m  input  1  system clock, 4 MHz; all logic on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- cent20  input  1  20 ct coin detected (pulse, ≥1 cycle).
- cent50  input  1  50 ct coin detected.
- euro01  input  1  1 € coin detected (100 ct).
- stop_buy  input  1  customer cancel request.
- coffee_ready  input  1  brewer reports coffee finished.
- cup_out  input  1  cup has been removed.
- prepare_coffee  output  1  start/keep brewing.
- green  output  1  "take your cup" lamp.
- return_cash  output  1  refund pulse; refunds all held credit.
- lock_slit  output  1  coin slit locked; no coins are accepted.

## Operation
- Coin inputs are rising-edge detected. Each 0→1 transition counts exactly once, regardless of pulse length.
- Credit register: 8 bits, unsigned, in cents. Coins arriving in the same cycle are summed: 20, 50 or 100 each.
- States:
  - IDLE: credit = 0. A coin edge adds its value to credit.
    - credit ≥ PRICE_CENTS → BREW.
    - credit > 0 → COLLECT.
  - COLLECT: further coin edges add to credit.
    - credit ≥ PRICE_CENTS → BREW.
    - else stop_buy = 1 → REFUND.
  - BREW: credit is cleared on entry. Overpayment is retained; no change is given.
    - prepare_coffee = 1, lock_slit = 1.
    - coffee_ready = 1 → CUP.
  - CUP: green = 1, lock_slit = 1.
    - cup_out = 1 → IDLE.
  - REFUND: return_cash = 1 for exactly one cycle. Credit is cleared. Then → IDLE.
- Moore outputs decoded from the state register only. All outputs are 0 in IDLE and COLLECT.
- stop_buy in IDLE: ignored. stop_buy in BREW or CUP: ignored.
- Coin edges in BREW, CUP or REFUND: ignored and not credited. The edge detector still tracks, so a coin held across the exit does not count later.
- Coin reaching price and stop_buy in the same cycle: the coin wins → BREW.
- coffee_ready asserted outside BREW: ignored. cup_out asserted outside CUP: ignored.

## Timing
- Reset (rst_n = 0, any time, including mid-brew) forces:
  - state = IDLE, credit = 0, edge-detect history = 0.
  - all outputs = 0.
- Coin edge sampled at rising edge N: credit and state update at edge N. prepare_coffee is high in the cycle after N.
- coffee_ready sampled at edge M: prepare_coffee falls and green rises after M.
- cup_out sampled at edge K: green and lock_slit fall after K.
- stop_buy sampled at edge S: return_cash is high for the cycle after S, low thereafter.
- No combinational input→output paths.

## Structure
- Package coffee_1058_pkg:
  - state enum: IDLE, COLLECT, BREW, CUP, REFUND.
  - coin value constants: CENT20 = 20, CENT50 = 50, EURO01 = 100.
  - credit width constant: 8.
- One sub-module, coin_edge_det: 3-bit registered rising-edge detector for cent20, cent50 and euro01.
- Top module contains the FSM and the credit adder.

## Test plan
- Reset, then 3× cent20 one-cycle pulses:
  - credit 20→40→60.
  - prepare_coffee and lock_slit high the cycle after the third pulse.
  - coffee_ready pulse → green = 1, prepare_coffee = 0.
  - cup_out pulse → all outputs 0.
- cent20 then cent50 (70 ct) → BREW entered after the second coin; no return_cash. Complete with coffee_ready, then cup_out.
- cent20, cent20, then stop_buy → return_cash high exactly one cycle, then IDLE with credit 0. A following 60 ct purchase needs the full 60 ct again.
- Single euro01 from IDLE → BREW directly. cent20 pulses during BREW are not credited: after cup_out, three more cent20 are needed for the next coffee.
- Assert rst_n = 0 during BREW → all outputs 0 immediately (asynchronous). After release the FSM is in IDLE.
- cent50 held high 5 cycles → credited once (50). stop_buy during CUP is ignored.
